// File: rtl/mips_main_control_if.sv
// Control bundle between the multicycle MIPS main control unit and the
// datapath: instruction opcode and memory handshake in, mux selects,
// write strobes and ALUOp out.
interface mips_main_control_if;
  logic [5:0] op_code;
  logic       mem_ready;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       zero_ext;
  logic [1:0] PCSrc;
  logic       PCWrite;
  logic       branch_eq;
  logic       branch_ne;
  logic       illegal_op;
  logic [3:0] state;

  // Control unit side.
  modport master (
    input  op_code, mem_ready,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, ALUOp, zero_ext, PCSrc, PCWrite, branch_eq, branch_ne,
           illegal_op, state
  );

  // Datapath / IR / memory side.
  modport slave (
    output op_code, mem_ready,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, ALUOp, zero_ext, PCSrc, PCWrite, branch_eq, branch_ne,
           illegal_op, state
  );
endinterface

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control unit: Moore FSM stepping each instruction
// through fetch/decode/execute/memory/writeback and driving datapath
// selects, write strobes and the ALUOp code for alu_control.
module mips_main_control (
  input  logic                clk,
  input  logic                rstb,
  mips_main_control_if.master bus
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_IEXEC    = 4'd9;
  localparam logic [3:0] S_IWB      = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [3:0] state_r;
  logic [3:0] next_state_s;

  logic       iord_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_dst_s;
  logic       mem_to_reg_s;
  logic       reg_write_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic       zero_ext_s;
  logic [1:0] pc_src_s;
  logic       pc_write_s;
  logic       branch_eq_s;
  logic       branch_ne_s;
  logic       illegal_op_s;

  // Logical immediates (ANDI/ORI/XORI) use a zero-extended immediate.
  function automatic logic is_logic_imm(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

  // Every opcode this unit knows how to sequence.
  function automatic logic is_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
      OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  // State register; reset drops straight back to FETCH without a clock.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state sequencing; memory states wait on mem_ready, 12-15 recover to FETCH.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH:    next_state_s = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op_code)
          OP_LW, OP_SW:                              next_state_s = S_MEMADR;
          OP_RTYPE:                                  next_state_s = S_EXECUTE;
          OP_BEQ, OP_BNE:                            next_state_s = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: next_state_s = S_IEXEC;
          OP_J:                                      next_state_s = S_JUMP;
          default:                                   next_state_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        case (bus.op_code)
          OP_LW:   next_state_s = S_MEMREAD;
          OP_SW:   next_state_s = S_MEMWRITE;
          default: next_state_s = S_FETCH;
        endcase
      end
      S_MEMREAD:  next_state_s = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state_s = S_FETCH;
      S_MEMWRITE: next_state_s = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  next_state_s = S_ALUWB;
      S_ALUWB:    next_state_s = S_FETCH;
      S_BRANCH:   next_state_s = S_FETCH;
      S_IEXEC:    next_state_s = S_IWB;
      S_IWB:      next_state_s = S_FETCH;
      S_JUMP:     next_state_s = S_FETCH;
      default:    next_state_s = S_FETCH;
    endcase
  end

  // Per-state datapath controls; only a few signals look at op_code or mem_ready.
  always_comb begin
    iord_s       = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    zero_ext_s   = 1'b0;
    pc_src_s     = 2'b00;
    pc_write_s   = 1'b0;
    branch_eq_s  = 1'b0;
    branch_ne_s  = 1'b0;
    illegal_op_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        alu_src_b_s = 2'b01;
        ir_write_s  = bus.mem_ready;
        pc_write_s  = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_b_s  = 2'b11;
        illegal_op_s = ~is_supported(bus.op_code);
      end
      S_MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      S_MEMREAD: begin
        iord_s = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
      end
      S_MEMWRITE: begin
        iord_s      = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'b10;
      end
      S_ALUWB: begin
        reg_dst_s   = 1'b1;
        reg_write_s = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'b01;
        pc_src_s    = 2'b01;
        branch_eq_s = (bus.op_code == OP_BEQ);
        branch_ne_s = (bus.op_code == OP_BNE);
      end
      S_IEXEC: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        alu_op_s    = 2'b11;
        zero_ext_s  = is_logic_imm(bus.op_code);
      end
      S_IWB: begin
        reg_write_s = 1'b1;
        zero_ext_s  = is_logic_imm(bus.op_code);
      end
      S_JUMP: begin
        pc_src_s   = 2'b10;
        pc_write_s = 1'b1;
      end
      default: begin
        alu_src_b_s = 2'b00;
      end
    endcase
  end

  // Strobes are qualified by rstb so nothing writes while reset is held.
  assign bus.MemWrite   = mem_write_s  & rstb;
  assign bus.IRWrite    = ir_write_s   & rstb;
  assign bus.RegWrite   = reg_write_s  & rstb;
  assign bus.PCWrite    = pc_write_s   & rstb;
  assign bus.branch_eq  = branch_eq_s  & rstb;
  assign bus.branch_ne  = branch_ne_s  & rstb;
  assign bus.illegal_op = illegal_op_s & rstb;

  assign bus.IorD     = iord_s;
  assign bus.RegDst   = reg_dst_s;
  assign bus.MemtoReg = mem_to_reg_s;
  assign bus.ALUSrcA  = alu_src_a_s;
  assign bus.ALUSrcB  = alu_src_b_s;
  assign bus.ALUOp    = alu_op_s;
  assign bus.zero_ext = zero_ext_s;
  assign bus.PCSrc    = pc_src_s;
  assign bus.state    = state_r;

endmodule

// File: tb/tb_mips_main_control.sv
// Bench for mips_main_control: per-instruction step plans drive a reference
// model compared every cycle, plus directed literal checks.
module tb_mips_main_control;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  mips_main_control_if bus ();

  mips_main_control dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  typedef struct packed {
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop;
    logic       zext;
    logic [1:0] pcsrc;
    logic       pcwrite, beq, bne, illegal;
    logic [3:0] st;
  } outs_t;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Reference model: the step the instruction should be in, and the steps still ahead.
  int exp_step = 0;
  int plan[$];

  // Per-instruction observations of the DUT.
  int seq[$];
  int cnt_mw, cnt_rw, cnt_ir, cnt_pw, cnt_il;
  int aluop_seen[16], zext_seen[16], pcsrc_seen[16], beq_seen[16];
  int bne_seen[16], pw_seen[16], rw_seen[16], mtr_seen[16];

  logic [5:0] ops[11] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A,
                          6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};

  function automatic bit legal_op(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A,
                      6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};
  endfunction

  // Steps after FETCH for each instruction class.
  task automatic build_plan(input logic [5:0] op);
    plan.delete();
    plan.push_back(1);
    case (op)
      6'h23:                      begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
      6'h2B:                      begin plan.push_back(2); plan.push_back(5); end
      6'h00:                      begin plan.push_back(6); plan.push_back(7); end
      6'h04, 6'h05:               plan.push_back(8);
      6'h08, 6'h0A, 6'h0C, 6'h0D,
      6'h0E:                      begin plan.push_back(9); plan.push_back(10); end
      6'h02:                      plan.push_back(11);
      default:                    ;
    endcase
  endtask

  // What the outputs must be in a given step, from the control table.
  function automatic outs_t expect_outs(input int step, input logic [5:0] op,
                                        input logic mr, input logic rst);
    outs_t o;
    o = '0;
    o.st = step[3:0];
    case (step)
      0:  begin o.alusrcb = 2'b01; o.irwrite = mr & rst; o.pcwrite = mr & rst; end
      1:  begin o.alusrcb = 2'b11; o.illegal = rst & !legal_op(op); end
      2:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      3:  o.iord = 1'b1;
      4:  begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
      5:  begin o.iord = 1'b1; o.memwrite = 1'b1; end
      6:  begin o.alusrca = 1'b1; o.aluop = 2'b10; end
      7:  begin o.regdst = 1'b1; o.regwrite = 1'b1; end
      8:  begin o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01;
                o.beq = (op == 6'h04); o.bne = (op == 6'h05); end
      9:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluop = 2'b11;
                o.zext = op inside {6'h0C, 6'h0D, 6'h0E}; end
      10: begin o.regwrite = 1'b1; o.zext = op inside {6'h0C, 6'h0D, 6'h0E}; end
      11: begin o.pcsrc = 2'b10; o.pcwrite = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic outs_t actual_outs();
    outs_t a;
    a.iord = bus.IorD;       a.memwrite = bus.MemWrite; a.irwrite = bus.IRWrite;
    a.regdst = bus.RegDst;   a.memtoreg = bus.MemtoReg; a.regwrite = bus.RegWrite;
    a.alusrca = bus.ALUSrcA; a.alusrcb = bus.ALUSrcB;   a.aluop = bus.ALUOp;
    a.zext = bus.zero_ext;   a.pcsrc = bus.PCSrc;       a.pcwrite = bus.PCWrite;
    a.beq = bus.branch_eq;   a.bne = bus.branch_ne;     a.illegal = bus.illegal_op;
    a.st = bus.state;
    return a;
  endfunction

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin : compare
    outs_t e, a;
    if (check_en) begin
      e = expect_outs(exp_step, bus.op_code, bus.mem_ready, rstb);
      a = actual_outs();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs step=%0d op=%h: got %h expected %h",
                 exp_step, bus.op_code, a, e);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_advance(input logic mr);
    if (!rstb) begin
      exp_step = 0;
      plan.delete();
    end else if ((exp_step == 0 || exp_step == 3 || exp_step == 5) && !mr) begin
      exp_step = exp_step;
    end else if (plan.size() == 0) begin
      exp_step = 0;
    end else begin
      exp_step = plan.pop_front();
    end
  endtask

  task automatic clear_obs();
    seq.delete();
    cnt_mw = 0; cnt_rw = 0; cnt_ir = 0; cnt_pw = 0; cnt_il = 0;
    for (int i = 0; i < 16; i++) begin
      aluop_seen[i] = -1; zext_seen[i] = -1; pcsrc_seen[i] = -1; beq_seen[i] = -1;
      bne_seen[i] = -1;   pw_seen[i] = -1;   rw_seen[i] = -1;    mtr_seen[i] = -1;
    end
  endtask

  // One clock: drive mem_ready, observe mid-cycle, advance the model on the edge.
  task automatic cycle(input logic mr);
    int s;
    bus.mem_ready = mr;
    @(negedge clk);
    s = int'(bus.state);
    seq.push_back(s);
    cnt_mw += int'(bus.MemWrite);  cnt_rw += int'(bus.RegWrite);
    cnt_ir += int'(bus.IRWrite);   cnt_pw += int'(bus.PCWrite);
    cnt_il += int'(bus.illegal_op);
    aluop_seen[s] = int'(bus.ALUOp);   zext_seen[s] = int'(bus.zero_ext);
    pcsrc_seen[s] = int'(bus.PCSrc);   beq_seen[s] = int'(bus.branch_eq);
    bne_seen[s] = int'(bus.branch_ne); pw_seen[s] = int'(bus.PCWrite);
    rw_seen[s] = int'(bus.RegWrite);   mtr_seen[s] = int'(bus.MemtoReg);
    @(posedge clk);
    model_advance(mr);
    #1;
  endtask

  // mode 0: mem_ready always 1; 1: random; 2: three stall cycles in MEMWRITE.
  task automatic run_instr(input logic [5:0] op, input int mode, output int n);
    int   stall;
    logic mr;
    bus.op_code = op;
    build_plan(op);
    clear_obs();
    n = 0;
    stall = 0;
    do begin
      case (mode)
        0: mr = 1'b1;
        1: mr = ($urandom_range(0, 3) != 0);
        default: begin
          if (exp_step == 5 && stall < 3) begin mr = 1'b0; stall++; end
          else mr = 1'b1;
        end
      endcase
      cycle(mr);
      n++;
    end while ((plan.size() != 0 || exp_step != 0) && n < 500);
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL instr_timeout: op=%h did not complete in %0d cycles", op, n);
    end
  endtask

  initial begin
    int n;
    int idx;
    logic [5:0] op;

    rstb = 1'b0;
    bus.op_code = 6'h00;
    bus.mem_ready = 1'b1;
    exp_step = 0;
    clear_obs();
    #2;
    check_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", int'(bus.state), 0);
    check("rst_irwrite", int'(bus.IRWrite), 0);
    check("rst_pcwrite", int'(bus.PCWrite), 0);
    check("rst_alusrcb", int'(bus.ALUSrcB), 1);
    @(posedge clk);
    #1;
    rstb = 1'b1;
    #1;
    check("release_irwrite", int'(bus.IRWrite), 1);
    check("release_pcwrite", int'(bus.PCWrite), 1);

    // LW with memory always ready.
    run_instr(6'h23, 0, n);
    check("lw_cycles", n, 5);
    for (int i = 0; i < 5; i++) check("lw_state_seq", (i < seq.size()) ? seq[i] : -1, i);
    check("lw_aluop_memadr", aluop_seen[2], 0);
    check("lw_regwrite_count", cnt_rw, 1);
    check("lw_regwrite_memwb", rw_seen[4], 1);
    check("lw_memtoreg_memwb", mtr_seen[4], 1);

    // SW with three wait cycles in MEMWRITE.
    run_instr(6'h2B, 2, n);
    check("sw_cycles", n, 7);
    check("sw_memwrite_count", cnt_mw, 4);
    check("sw_regwrite_count", cnt_rw, 0);
    check("sw_end_state", int'(bus.state), 0);

    // R-type, then ORI, then ADDI.
    run_instr(6'h00, 0, n);
    check("r_cycles", n, 4);
    check("r_aluop_exec", aluop_seen[6], 2);
    run_instr(6'h0D, 0, n);
    check("ori_cycles", n, 4);
    check("ori_aluop_iexec", aluop_seen[9], 3);
    check("ori_zext_iexec", zext_seen[9], 1);
    check("ori_zext_iwb", zext_seen[10], 1);
    run_instr(6'h08, 0, n);
    check("addi_zext_iexec", zext_seen[9], 0);

    // BNE and J.
    run_instr(6'h05, 0, n);
    check("bne_cycles", n, 3);
    check("bne_aluop", aluop_seen[8], 1);
    check("bne_branch_ne", bne_seen[8], 1);
    check("bne_branch_eq", beq_seen[8], 0);
    check("bne_pcsrc", pcsrc_seen[8], 1);
    run_instr(6'h02, 0, n);
    check("j_cycles", n, 3);
    check("j_pcsrc", pcsrc_seen[11], 2);
    check("j_pcwrite", pw_seen[11], 1);

    // Unsupported opcode.
    run_instr(6'h3F, 0, n);
    check("illegal_cycles", n, 2);
    check("illegal_count", cnt_il, 1);
    check("illegal_regwrite", cnt_rw, 0);
    check("illegal_memwrite", cnt_mw, 0);
    check("illegal_pcwrite", cnt_pw, 1);
    check("illegal_end_state", int'(bus.state), 0);

    // Reset in the middle of a stalled store.
    bus.op_code = 6'h2B;
    build_plan(6'h2B);
    clear_obs();
    cycle(1'b1); cycle(1'b1); cycle(1'b1); cycle(1'b0);
    check("midrst_pre_memwrite", int'(bus.MemWrite), 1);
    #2;
    rstb = 1'b0;
    exp_step = 0;
    plan.delete();
    #1;
    check("midrst_state", int'(bus.state), 0);
    check("midrst_memwrite", int'(bus.MemWrite), 0);
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    rstb = 1'b1;
    #1;
    check("midrst_release_irwrite", int'(bus.IRWrite), 1);
    check("midrst_release_pcwrite", int'(bus.PCWrite), 1);

    // Randomized instruction stream with random memory stalls.
    for (int k = 0; k < 300; k++) begin
      idx = $urandom_range(0, 11);
      if (idx == 11) op = 6'($urandom_range(0, 63));
      else           op = ops[idx];
      run_instr(op, 1, n);
    end

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
